// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared constants and types for the streaming Sobel filter
package sobel_pkg;

    typedef enum logic {
        MAG_SAT   = 1'b0,
        MAG_SCALE = 1'b1
    } mag_mode_e;

    localparam int LATENCY = 2;

    typedef struct packed {
        logic vld;
        logic sof;
        logic eol;
        logic done;
    } side_t;

    function automatic int grad_w(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - two-row line buffer, read-before-write at the column address
module sobel_line_buffer #(
    parameter int COLS   = 480,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [$clog2(COLS)-1:0]   i_addr,
    input  logic [DATA_W-1:0]         i_data,
    output logic [DATA_W-1:0]         o_row1,
    output logic [DATA_W-1:0]         o_row2
);

    logic [DATA_W-1:0] r_mem1 [COLS];
    logic [DATA_W-1:0] r_mem2 [COLS];

    assign o_row1 = r_mem1[i_addr];
    assign o_row2 = r_mem2[i_addr];

    // Row r-1 slides down into the r-2 slot as the new pixel takes its place.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem1[i_addr] <= i_data;
            r_mem2[i_addr] <= r_mem1[i_addr];
        end
    end

endmodule

// File: rtl/sobel_stream_filter.sv
// rtl/sobel_stream_filter.sv - streaming 3x3 Sobel magnitude filter with frame sideband markers
module sobel_stream_filter
    import sobel_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COLS      = 480,
    parameter int ROWS      = 360,
    parameter int MAG_MODE  = 0,
    parameter int THRESH_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              sof_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W+2:0] thresh_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              sof_o,
    output logic              eol_o,
    output logic              frame_done_o
);

    localparam int GW = grad_w(DATA_W);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [DATA_W-1:0] PIX_MAX = '1;

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic [DATA_W-1:0] w_row1;
    logic [DATA_W-1:0] w_row2;
    logic              w_emit;
    side_t             w_side;
    side_t             r_side [LATENCY];

    logic [DATA_W-1:0]     r_win [3][3];
    logic signed [GW-1:0]  w_p   [3][3];
    logic signed [GW-1:0]  w_gx;
    logic signed [GW-1:0]  w_gy;
    logic signed [GW-1:0]  r_gx;
    logic signed [GW-1:0]  r_gy;
    logic [GW-1:0]         w_ax;
    logic [GW-1:0]         w_ay;
    logic [GW-1:0]         w_mag;
    logic [DATA_W-1:0]     w_out;

    // A start-of-frame pixel is (0,0) whatever the counters currently hold.
    assign w_col = sof_i ? '0 : r_col;
    assign w_row = sof_i ? '0 : r_row;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (we_i) begin
            if (w_col == CW'(COLS - 1)) begin
                r_col <= '0;
                r_row <= (w_row == RW'(ROWS - 1)) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    sobel_line_buffer #(
        .COLS   (COLS),
        .DATA_W (DATA_W)
    ) u_line_buffer (
        .clk    (clk),
        .i_we   (we_i),
        .i_addr (w_col),
        .i_data (data_i),
        .o_row1 (w_row1),
        .o_row2 (w_row2)
    );

    // r_win[row][col]: row 2 is the current image row, col 2 the newest column.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_row2;
            r_win[1][2] <= w_row1;
            r_win[2][2] <= data_i;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_p[r][c] = $signed({3'b000, r_win[r][c]});
            end
        end
        w_gx = (w_p[0][2] + (w_p[1][2] <<< 1) + w_p[2][2])
             - (w_p[0][0] + (w_p[1][0] <<< 1) + w_p[2][0]);
        w_gy = (w_p[2][0] + (w_p[2][1] <<< 1) + w_p[2][2])
             - (w_p[0][0] + (w_p[0][1] <<< 1) + w_p[0][2]);
    end

    always_ff @(posedge clk) begin
        r_gx <= w_gx;
        r_gy <= w_gy;
    end

    always_comb begin
        w_ax  = r_gx[GW-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
        w_ay  = r_gy[GW-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
        w_mag = w_ax + w_ay;
        w_out = '0;
        if (THRESH_EN != 0) begin
            w_out = (w_mag >= thresh_i) ? PIX_MAX : '0;
        end else if (MAG_MODE == int'(MAG_SCALE)) begin
            w_out = w_mag[DATA_W+2:3];
        end else begin
            w_out = (w_mag > GW'(PIX_MAX)) ? PIX_MAX : w_mag[DATA_W-1:0];
        end
    end

    assign w_emit      = we_i && (w_row >= RW'(2)) && (w_col >= CW'(2));
    assign w_side.vld  = w_emit;
    assign w_side.sof  = w_emit && (w_row == RW'(2)) && (w_col == CW'(2));
    assign w_side.eol  = w_emit && (w_col == CW'(COLS - 1));
    assign w_side.done = w_emit && (w_col == CW'(COLS - 1)) && (w_row == RW'(ROWS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_side[i] <= '0;
            end
            valid_o      <= 1'b0;
            data_o       <= '0;
            sof_o        <= 1'b0;
            eol_o        <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            r_side[0] <= w_side;
            for (int i = 1; i < LATENCY; i++) begin
                r_side[i] <= r_side[i-1];
            end
            valid_o      <= r_side[LATENCY-1].vld;
            sof_o        <= r_side[LATENCY-1].sof;
            eol_o        <= r_side[LATENCY-1].eol;
            frame_done_o <= r_side[LATENCY-1].done;
            if (r_side[LATENCY-1].vld) begin
                data_o <= w_out;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb/tb_sobel_stream_filter.sv - directed table-driven bench for sobel_stream_filter (8x6 frames)
module tb_sobel_stream_filter;

    localparam int C = 8;
    localparam int R = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic        sof_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic [10:0] thresh_i = 11'd80;

    logic       vo_sat, vo_scl, vo_thr;
    logic [7:0] do_sat, do_scl, do_thr;
    logic       so_sat, so_scl, so_thr;
    logic       eo_sat, eo_scl, eo_thr;
    logic       fo_sat, fo_scl, fo_thr;

    sobel_stream_filter #(.DATA_W(8), .COLS(C), .ROWS(R), .MAG_MODE(0), .THRESH_EN(0)) dut_sat (
        .clk(clk), .rst(rst), .we_i(we_i), .sof_i(sof_i), .data_i(data_i), .thresh_i(thresh_i),
        .valid_o(vo_sat), .data_o(do_sat), .sof_o(so_sat), .eol_o(eo_sat), .frame_done_o(fo_sat));

    sobel_stream_filter #(.DATA_W(8), .COLS(C), .ROWS(R), .MAG_MODE(1), .THRESH_EN(0)) dut_scl (
        .clk(clk), .rst(rst), .we_i(we_i), .sof_i(sof_i), .data_i(data_i), .thresh_i(thresh_i),
        .valid_o(vo_scl), .data_o(do_scl), .sof_o(so_scl), .eol_o(eo_scl), .frame_done_o(fo_scl));

    sobel_stream_filter #(.DATA_W(8), .COLS(C), .ROWS(R), .MAG_MODE(0), .THRESH_EN(1)) dut_thr (
        .clk(clk), .rst(rst), .we_i(we_i), .sof_i(sof_i), .data_i(data_i), .thresh_i(thresh_i),
        .valid_o(vo_thr), .data_o(do_thr), .sof_o(so_thr), .eol_o(eo_thr), .frame_done_o(fo_thr));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sat;
        int scl;
        int thr;
        bit sof;
        bit eol;
        bit fd;
        int at;
    } exp_t;

    typedef struct {
        string            name;
        int               pat;
        logic [10:0]      thr;
        int               gap;
        bit               sof;
        bit               drain;
        int               n_exp;
        logic [5:0][7:0]  t_sat;
        logic [5:0][7:0]  t_scl;
        logic [5:0][7:0]  t_thr;
    } vec_t;

    exp_t q[$];
    exp_t m_e;
    vec_t tbl[5];
    logic [5:0][7:0] cur_sat, cur_scl, cur_thr;
    int mr = 0;
    int mc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n_out = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pix(input int pat, input int c);
        case (pat)
            0:       return 8'd100;
            1:       return (c < 4) ? 8'd0 : 8'd255;
            default: return 8'(10 * c);
        endcase
    endfunction

    task automatic drive_px(input logic [7:0] d, input bit s, input int gap);
        exp_t e;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            we_i = 1'b0;
            sof_i = 1'b0;
        end
        @(negedge clk);
        we_i = 1'b1;
        data_i = d;
        sof_i = s;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        if (mr >= 2 && mc >= 2) begin
            e.sat = cur_sat[mc-2];
            e.scl = cur_scl[mc-2];
            e.thr = cur_thr[mc-2];
            e.sof = (mr == 2 && mc == 2);
            e.eol = (mc == C - 1);
            e.fd  = (mr == R - 1 && mc == C - 1);
            e.at  = cyc + 3;
            q.push_back(e);
        end
        mc++;
        if (mc == C) begin
            mc = 0;
            mr = (mr == R - 1) ? 0 : mr + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            we_i = 1'b0;
            sof_i = 1'b0;
        end
    endtask

    task automatic run_frame(input int pat, input bit s, input int gapmax, input int npx);
        for (int i = 0; i < npx; i++) begin
            drive_px(pix(pat, i % C), s && (i == 0),
                     (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
        end
    endtask

    task automatic drain_check(input string nm, input int n_exp);
        idle(6);
        chk({nm, "_outputs"}, n_out, n_exp);
        chk({nm, "_pending"}, q.size(), 0);
        q.delete();
        n_out = 0;
    endtask

    always @(negedge clk) begin
        if (rst && (vo_sat || vo_scl || vo_thr)) begin
            n_out++;
            chk("valid_agree", {vo_sat, vo_scl, vo_thr}, 3'b111);
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                m_e = q.pop_front();
                chk("data_sat", do_sat, m_e.sat);
                chk("data_scl", do_scl, m_e.scl);
                chk("data_thr", do_thr, m_e.thr);
                chk("flags_sat", {so_sat, eo_sat, fo_sat}, {m_e.sof, m_e.eol, m_e.fd});
                chk("flags_other", {so_scl, eo_scl, fo_scl, so_thr, eo_thr, fo_thr},
                    {m_e.sof, m_e.eol, m_e.fd, m_e.sof, m_e.eol, m_e.fd});
                chk("latency", cyc, m_e.at);
            end
        end
    end

    initial begin
        tbl[0] = '{"const",      0, 11'd80, 0, 1'b1, 1'b0, 0,
                   {6{8'd0}}, {6{8'd0}}, {6{8'd0}}};
        tbl[1] = '{"step_b2b",   1, 11'd80, 0, 1'b0, 1'b1, 48,
                   {8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0},
                   {8'd0, 8'd0, 8'd127, 8'd127, 8'd0, 8'd0},
                   {8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0}};
        tbl[2] = '{"ramp_th80",  2, 11'd80, 0, 1'b1, 1'b1, 24,
                   {6{8'd80}}, {6{8'd10}}, {6{8'd255}}};
        tbl[3] = '{"ramp_th81",  2, 11'd81, 0, 1'b1, 1'b1, 24,
                   {6{8'd80}}, {6{8'd10}}, {6{8'd0}}};
        tbl[4] = '{"step_gaps",  1, 11'd80, 3, 1'b1, 1'b1, 24,
                   {8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0},
                   {8'd0, 8'd0, 8'd127, 8'd127, 8'd0, 8'd0},
                   {8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0}};

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", {vo_sat, vo_scl, vo_thr}, 0);
        chk("reset_data", {do_sat, do_scl, do_thr}, 0);
        chk("reset_flags", {so_sat, eo_sat, fo_sat, so_scl, eo_scl, fo_scl, so_thr, eo_thr, fo_thr}, 0);
        rst = 1'b1;
        idle(2);

        for (int i = 0; i < 5; i++) begin
            thresh_i = tbl[i].thr;
            cur_sat  = tbl[i].t_sat;
            cur_scl  = tbl[i].t_scl;
            cur_thr  = tbl[i].t_thr;
            run_frame(tbl[i].pat, tbl[i].sof, tbl[i].gap, C * R);
            if (tbl[i].drain) drain_check(tbl[i].name, tbl[i].n_exp);
        end

        // sof_i on pixel 20: two in-flight outputs survive, then a clean frame
        thresh_i = 11'd80;
        cur_sat  = tbl[1].t_sat;
        cur_scl  = tbl[1].t_scl;
        cur_thr  = tbl[1].t_thr;
        run_frame(1, 1'b1, 0, 20);
        run_frame(1, 1'b1, 0, C * R);
        drain_check("sof_mid", 26);

        // asynchronous reset while outputs are streaming
        run_frame(1, 1'b1, 0, 30);
        @(negedge clk);
        we_i = 1'b0;
        sof_i = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_reset_valid", vo_sat, 1);
        chk("pre_reset_data", do_sat, 255);
        rst = 1'b0;
        #1;
        chk("async_reset_valid", {vo_sat, vo_scl, vo_thr}, 0);
        chk("async_reset_data", {do_sat, do_scl, do_thr}, 0);
        chk("pre_reset_outputs", n_out, 8);
        q.delete();
        n_out = 0;
        mr = 0;
        mc = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_frame(1, 1'b0, 0, C * R);
        drain_check("post_reset", 24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_stream_filter.md
Name: sobel_stream_filter

Overview:
- Parametrised successor to the fixed 480x360, 8-bit Sobel kernel.
- Streaming 3x3 Sobel edge filter: raster pixels in, gradient magnitude of every interior pixel out.
- Owns its two-row line buffer, frame position counters, magnitude mode, optional threshold binarisation and sideband markers (sof/eol/frame_done).
- Sits between the grayscale stage and the output writer in the edge-detection pipeline.

Parameters:
- DATA_W, 8, pixel width in bits (input and output).
- COLS, 480, image width in pixels (>=3).
- ROWS, 360, image height in pixels (>=3).
- MAG_MODE, 0, 0 = saturate |Gx|+|Gy| to 2^DATA_W-1; 1 = scale |Gx|+|Gy| right by 3.
- THRESH_EN, 0, 1 = binarise the magnitude against thresh_i.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- we_i  in  1  input pixel valid; no backpressure.
- sof_i  in  1  with we_i, marks the pixel as (0,0) of a new frame.
- data_i  in  DATA_W  unsigned grayscale pixel.
- thresh_i  in  DATA_W+3  binarisation threshold; sampled in stage 2.
- valid_o  out  1  output pixel valid.
- data_o  out  DATA_W  edge magnitude, or binary 0 / 2^DATA_W-1.
- sof_o  out  1  with valid_o, first interior pixel (1,1).
- eol_o  out  1  with valid_o, last interior pixel of a row (column COLS-2).
- frame_done_o  out  1  with valid_o, last interior pixel (ROWS-2,COLS-2).

Behaviour:
- Reset (rst=0, asynchronous):
  - valid_o, data_o, sof_o, eol_o and frame_done_o go to 0 immediately.
  - Column/row counters and the pipeline valid bits clear.
  - Line buffer RAM and window data are not reset.
- Counters:
  - col advances 0..COLS-1 on each we_i; at wrap, row advances 0..ROWS-1.
  - After (ROWS-1,COLS-1), both counters return to 0 and the next frame starts with no idle cycle.
  - we_i && sof_i forces the current pixel to (0,0) regardless of counter state, and discards any partial window.
- Window:
  - 3x3 shift window; advances only on we_i; gaps in we_i are allowed.
  - The line buffer holds rows r-1 and r-2, one read/write per accepted pixel at address col.
- Emission:
  - An output is produced when the accepted pixel at (r,c) has r>=2 and c>=2.
  - Its centre is (r-1,c-1), giving (ROWS-2)*(COLS-2) outputs per frame in raster order.
  - Border pixels are not emitted.
- Pipeline (latency 2 cycles):
  - Stage 1: registered window; Gx, Gy signed, DATA_W+3 bits, standard Sobel coefficients.
  - Stage 2: mag = |Gx|+|Gy|, unsigned DATA_W+3 bits.
    - MAG_MODE 0: data_o = min(mag, 2^DATA_W-1).
    - MAG_MODE 1: data_o = mag>>3, truncated to DATA_W bits.
    - THRESH_EN=1 overrides: data_o = (mag >= thresh_i) ? 2^DATA_W-1 : 0.
  - valid_o is high exactly 2 clocks after the completing we_i edge, for one cycle.
  - The pipeline is free-running: outputs from back-to-back inputs appear on consecutive cycles.
- Frame boundaries:
  - Stale line-buffer data from the previous frame is never used, because rows 0-1 emit nothing.
  - A sof_i mid-frame does not abort outputs already in the pipeline.

Decomposition:
- Package sobel_pkg:
  - MAG_SAT / MAG_SCALE mode encodings.
  - GRAD_W(DATA_W) = DATA_W+3 constant function.
  - Pipeline LATENCY = 2.
- Sub-module sobel_line_buffer:
  - Parameters COLS, DATA_W.
  - Two-row RAM with read-before-write at address col.
  - Returns the pixels at (r-1,col) and (r-2,col).

Test Plan (COLS=8, ROWS=6; 24 outputs per frame):
1. Constant frame of value 100, continuous we_i:
   - 24 valid_o pulses, all data_o=0.
   - sof_o on the 1st pulse, eol_o every 6th, frame_done_o on the 24th.
   - First valid_o 2 cycles after input pixel 18.
2. Vertical step (columns 0-3 = 0, columns 4-7 = 255), MAG_MODE 0:
   - Centres at columns 3 and 4: Gx=1020, data_o=255; all others 0.
   - Same stimulus with MAG_MODE 1: data_o=127 at those centres.
3. Horizontal ramp (pixel = 10*c), THRESH_EN=1:
   - mag=80 at every centre.
   - thresh_i=80 gives all 255; thresh_i=81 gives all 0.
4. Test 2 stimulus with random 0-3 cycle we_i gaps:
   - Identical output sequence to test 2.
   - Each valid_o exactly 2 cycles after its completing input.
5. sof_i asserted on input pixel 20, then a full frame:
   - Outputs already in flight still appear.
   - Then no outputs until the 19th pixel of the new frame, then 24 correct outputs.
6. rst low mid-frame (after 30 inputs):
   - valid_o and data_o drop to 0 without waiting for a clock edge.
   - After release, a fresh frame yields exactly 24 correct outputs with frame_done_o.
